// File: rtl/modadd_sched.sv
// Two-requester scheduler + 2-stage modular add/sub (mod P); MODADD_RR_EN selects round-robin over fixed priority.
// Latency: accept at edge k, rsp_valid high in the cycle after edge k+1; one op per cycle.
// Backpressure: none; responses must be consumed when rsp_valid is high.
module modadd_sched #(
  parameter int WIDTH = 256,
  parameter logic [WIDTH-1:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

`ifdef MODADD_RR_EN
  logic ptr;

  assign gnt0 = !rst && req0 && (!req1 || !ptr);
  assign gnt1 = !rst && req1 && (!req0 || ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end
`else
  assign gnt0 = !rst && req0;
  assign gnt1 = !rst && req1 && !req0;
`endif

  logic             accept;
  logic             op_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH:0]   raw_n;

  assign accept = gnt0 || gnt1;
  assign op_s   = gnt1 ? op1 : op0;
  assign a_s    = gnt1 ? a1 : a0;
  assign b_s    = gnt1 ? b1 : b0;
  // Top bit is the carry for add and the borrow for subtract.
  assign raw_n  = op_s ? ({1'b0, a_s} - {1'b0, b_s}) : ({1'b0, a_s} + {1'b0, b_s});

  logic [WIDTH:0]   raw;
  logic             op_r;
  logic             id_r;
  logic             v1;

  logic [WIDTH-1:0] alt;
  logic             sel;

  // Only the low WIDTH bits of raw - P survive, so the subtraction is done at WIDTH bits.
  assign alt = op_r ? (raw[WIDTH-1:0] + P) : (raw[WIDTH-1:0] - P);
  assign sel = op_r ? raw[WIDTH] : (raw >= {1'b0, P});

  always_ff @(posedge clk) begin
    if (rst) begin
      raw       <= '0;
      op_r      <= 1'b0;
      id_r      <= 1'b0;
      v1        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        raw  <= raw_n;
        op_r <= op_s;
        id_r <= gnt1;
      end
      rsp_valid <= v1;
      if (v1) begin
        rsp_id   <= id_r;
        rsp_data <= sel ? alt : raw[WIDTH-1:0];
      end
    end
  end

  assign busy = v1 || rsp_valid;

endmodule

// File: tb/tb_modadd_sched.sv
// Bench for modadd_sched: one instance at the secp256k1 prime, one at P=23, sharing requests.
module tb_modadd_sched;
  localparam logic [255:0] PB = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] PS = 256'd23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [255:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [255:0] sa0, sb0, sa1, sb1;

  logic gnt0, gnt1, rsp_valid, rsp_id, busy;
  logic [255:0] rsp_data;
  logic s_gnt0, s_gnt1, s_rsp_valid, s_rsp_id, s_busy;
  logic [255:0] s_rsp_data;

  assign sa0 = a0 % PS;
  assign sb0 = b0 % PS;
  assign sa1 = a1 % PS;
  assign sb1 = b1 % PS;

  always #5 clk = ~clk;

  modadd_sched dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  modadd_sched #(.P(PS)) dut_s (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(sa0), .b0(sb0), .a1(sa1), .b1(sb1), .gnt0(s_gnt0), .gnt1(s_gnt1),
    .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data), .busy(s_busy)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         id;
    logic [255:0] d;
    logic [255:0] ds;
    int           due;
  } pend_t;

  pend_t        pq[$];
  int           cyc = 0;
  logic         m_valid = 1'b0, m_id = 1'b0, m_ptr = 1'b0;
  logic [255:0] m_data = '0, m_ds = '0;
  logic         mg0, mg1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // (a + b) mod p or (a - b) mod p, straight from the field definition.
  function automatic logic [255:0] refm(input logic [255:0] a, input logic [255:0] b,
                                        input logic op, input logic [255:0] p);
    logic [257:0] w;
    if (!op) w = ({2'b0, a} + {2'b0, b}) % {2'b0, p};
    else     w = ({2'b0, a} + {2'b0, p} - {2'b0, b}) % {2'b0, p};
    return w[255:0];
  endfunction

  function automatic logic [255:0] rnd();
    logic [255:0] x;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: x = '0;
      1: x = PB - 256'd1;
      default: if (x >= PB) x = x - PB;
    endcase
    return x;
  endfunction

  task automatic tick();
    pend_t p;
    logic [255:0] xa, xb;
    logic xo;
    @(negedge clk);
`ifdef MODADD_RR_EN
    mg0 = !rst && req0 && (!req1 || m_ptr == 1'b0);
    mg1 = !rst && req1 && (!req0 || m_ptr == 1'b1);
`else
    mg0 = !rst && req0;
    mg1 = !rst && req1 && !req0;
`endif
    chk("gnt0", {255'b0, gnt0}, {255'b0, mg0});
    chk("gnt1", {255'b0, gnt1}, {255'b0, mg1});
    chk("s_gnt0", {255'b0, s_gnt0}, {255'b0, mg0});
    chk("s_gnt1", {255'b0, s_gnt1}, {255'b0, mg1});
    chk("rsp_valid", {255'b0, rsp_valid}, {255'b0, m_valid});
    chk("s_rsp_valid", {255'b0, s_rsp_valid}, {255'b0, m_valid});
    chk("busy", {255'b0, busy}, {255'b0, m_valid || pq.size() > 0});
    chk("s_busy", {255'b0, s_busy}, {255'b0, m_valid || pq.size() > 0});
    chk("rsp_data", rsp_data, m_data);
    chk("s_rsp_data", s_rsp_data, m_ds);
    if (m_valid) begin
      chk("rsp_id", {255'b0, rsp_id}, {255'b0, m_id});
      chk("s_rsp_id", {255'b0, s_rsp_id}, {255'b0, m_id});
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      pq.delete();
      m_valid = 1'b0;
      m_id = 1'b0;
      m_data = '0;
      m_ds = '0;
      m_ptr = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        p = pq.pop_front();
        m_valid = 1'b1;
        m_id = p.id;
        m_data = p.d;
        m_ds = p.ds;
      end
      if (mg0 || mg1) begin
        xa = mg1 ? a1 : a0;
        xb = mg1 ? b1 : b0;
        xo = mg1 ? op1 : op0;
        p.id = mg1;
        p.d = refm(xa, xb, xo, PB);
        p.ds = refm(xa % PS, xb % PS, xo, PS);
        p.due = cyc + 1;
        pq.push_back(p);
        m_ptr = mg0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic r0, input logic r1, input logic o0, input logic o1,
                       input logic [255:0] x0, input logic [255:0] y0,
                       input logic [255:0] x1, input logic [255:0] y1);
    req0 = r0; req1 = r1; op0 = o0; op1 = o1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    // Reset with a pending request: grants must stay low, outputs at zero.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 256'd1, 256'd2, 256'd3, 256'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 256'd1, 256'd2, 256'd3, 256'd4);
    chk("reset_rsp_id", {255'b0, rsp_id}, 256'd0);
    rst = 1'b0;
    idle(1);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 256'd20, 256'd5, '0, '0);
    idle(3);

    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 256'd3, 256'd7);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 256'd7, 256'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 256'd5, 256'd5);
    idle(3);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 256'd11, 256'd12, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 256'd22, 256'd0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, PB - 256'd1, PB - 256'd1, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 256'd0, PB - 256'd1);
    idle(3);

    // Sustained contention with fresh operands, then requester 0 drops.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, $urandom_range(0, 1), $urandom_range(0, 1), rnd(), rnd(), rnd(), rnd());
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, rnd(), rnd());
    idle(3);

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            rnd(), rnd(), rnd(), rnd());
    idle(3);

    // Reset while two ops are in flight: anything not yet delivered is dropped.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 256'd9, 256'd10, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, '0, '0, 256'd4, 256'd6);
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 256'd1, 256'd1, 256'd1, 256'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 256'd1, 256'd1, 256'd1, 256'd1);
    rst = 1'b0;
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 256'd15, 256'd13, '0, '0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
